param_stream_sink: RTL and testbench
====================================

Name: param_stream_sink

Overview:
- Receiving end of the parameter streaming interface.
- Accepts IN_DEPTH beats of IN_SIZE-lane vectors over a valid/ready handshake and packs each beat into one word of an internal RAM.
- Exposes a ROM-style read port (address, ce, 2-cycle registered data) so captured parameters or activations can be read back by downstream logic or a testbench.
- Asserts full once a complete block has been captured and refuses further beats until rearmed.

Parameters:
IN_SIZE, 32, number of lanes per beat
IN_WIDTH, 16, bits per lane
IN_DEPTH, 8, beats per block (RAM depth, >=1)
ADDR_WIDTH, $clog2(IN_DEPTH)+1, width of address and count ports (one bit wider so IN_DEPTH fits)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
data_in  input  IN_WIDTH x [IN_SIZE]  unpacked lane array, lane j = data_in[j]
data_in_valid  input  1  beat present
data_in_ready  output  1  sink can accept beat
rearm  input  1  single-cycle request to start a new capture block
full  output  1  block of IN_DEPTH beats captured
count  output  ADDR_WIDTH  beats captured in current block, 0..IN_DEPTH
rd_addr  input  ADDR_WIDTH  read address
rd_ce  input  1  read pipeline enable
rd_q  output  IN_WIDTH*IN_SIZE  read data, lane j at bits [IN_WIDTH*j +: IN_WIDTH]

Behaviour:
- Reset (rst low, asynchronous): state=FILL, wr_ptr=0, count=0, full=0, both read pipeline registers=0. RAM contents are not reset.
- Reset release: takes effect on the next rising clk edge.
- Reset mid-block: discards progress. Already-written RAM words keep their values.
- FSM states:
  - FILL: data_in_ready = !rearm; full=0.
  - FULL: data_in_ready=0; full=1.
- Accept condition: data_in_valid & data_in_ready.
- On accept:
  - Flattened word {data_in[IN_SIZE-1],...,data_in[0]} is written to mem[wr_ptr].
  - count increments.
  - If wr_ptr==IN_DEPTH-1: wr_ptr wraps to 0 and state goes to FULL. Otherwise wr_ptr increments.
  - count equals IN_DEPTH while in FULL.
- IN_DEPTH=1: first accept goes straight to FULL.
- No overflow path: in FULL, ready is low and valid is ignored. The source must hold valid/data stable until ready (standard handshake; the sink does not buffer).
- rearm:
  - In FULL: next state FILL, count=0, wr_ptr=0.
  - In FILL: aborts the partial block (count=0, wr_ptr=0). ready is forced low that cycle, so a simultaneous beat is not accepted and must be re-presented.
  - rearm and a final accept can never coincide.
- full and count are registered and update the cycle after the causing edge. data_in_ready is combinational from state and rearm only; it never depends on valid.
- Read port:
  - Stage 1 on clk when rd_ce: q_t0 <= mem[rd_addr].
  - Stage 2 on clk when rd_ce: q_t1 <= q_t0.
  - rd_q = q_t1, so latency is 2 rd_ce-enabled cycles. With rd_ce low both stages hold.
- rd_addr >= IN_DEPTH: stage 1 loads 0.
- Read and write to the same address in the same cycle: the read returns the old word (read-before-write).
- The read port operates in any state and has no effect on FSM or count.

Test Plan:
- Reset, then fill: hold rst low 3 cycles -> full=0, count=0, rd_q=0, ready=1. Stream 8 beats with lane j = 16'(beat*32+j), valid always high -> count 1..8, full=1 the cycle after the 8th accept, then ready=0.
- Readback: after full, rd_ce=1, sweep rd_addr 0..7 -> rd_q lane j of addr a = a*32+j, appearing 2 cycles after the address. rd_addr=8 -> rd_q=0.
- Backpressure, rearm, new block: present a beat while full for 5 cycles -> no write, mem[0] unchanged. Pulse rearm -> next cycle full=0, count=0, ready=1. Pending beat 0xAAAA in all lanes accepted into addr 0.
- Rearm during fill: after 3 accepts, assert rearm with valid high -> ready=0 that cycle, count=0 next cycle. Next accepted beat lands at addr 0.
- Valid gaps and async reset: toggle valid randomly, check count equals handshake count. Drop rst asynchronously mid-cycle at count=5 -> full=0, count=0 immediately. Recovery fill of 8 beats completes normally.
- Read/write collision: write 0x1234 (all lanes) to addr 2 over old 0x5555 while reading addr 2 the same cycle -> rd_q=0x5555 lanes. Re-read -> 0x1234. Hold rd_ce=0 -> rd_q stays stable.

Source files
------------

// File: rtl/param_stream_sink.sv
// Receiving end of the parameter stream: captures IN_DEPTH beats of IN_SIZE lanes into a RAM
// and offers a two-stage registered read port for downstream logic.
module param_stream_sink #(
    parameter int IN_SIZE    = 32,
    parameter int IN_WIDTH   = 16,
    parameter int IN_DEPTH   = 8,
    parameter int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_WIDTH-1:0]          data_in [IN_SIZE],
    input  logic                         data_in_valid,
    output logic                         data_in_ready,
    input  logic                         rearm,
    output logic                         full,
    output logic [ADDR_WIDTH-1:0]        count,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic                         rd_ce,
    output logic [IN_WIDTH*IN_SIZE-1:0]  rd_q
);

    localparam int WORD_W    = IN_WIDTH * IN_SIZE;
    localparam int IDX_W     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int MEM_DEPTH = 1 << IDX_W;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        wr_ptr;
    logic [WORD_W-1:0]       wr_word;
    logic                    accept;
    logic                    last_beat;
    logic [WORD_W-1:0]       mem [MEM_DEPTH];
    logic [WORD_W-1:0]       q_t0;
    logic [WORD_W-1:0]       q_t1;
    logic                    rd_in_range;
    logic [IDX_W-1:0]        rd_idx;

    // Handshake: a beat transfers on a rising edge where data_in_valid and data_in_ready are
    // both high; the source holds valid/data until then. Ready never looks at valid.
    assign data_in_ready = (state == FILL) && !rearm;
    assign accept        = data_in_valid && data_in_ready;
    assign last_beat     = (wr_ptr == IDX_W'(IN_DEPTH - 1));

    always_comb begin
        wr_word = '0;
        for (int j = 0; j < IN_SIZE; j++) begin
            wr_word[IN_WIDTH*j +: IN_WIDTH] = data_in[j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FILL;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (rearm) begin
                        wr_ptr <= '0;
                        count  <= '0;
                    end else if (accept) begin
                        count <= count + ADDR_WIDTH'(1);
                        if (last_beat) begin
                            wr_ptr <= '0;
                            state  <= FULL;
                            full   <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (rearm) begin
                        state  <= FILL;
                        full   <= 1'b0;
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                    full  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    assign rd_in_range = (rd_addr < ADDR_WIDTH'(IN_DEPTH));
    assign rd_idx      = rd_addr[IDX_W-1:0];

    // Non-blocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_t0 <= '0;
            q_t1 <= '0;
        end else if (rd_ce) begin
            q_t0 <= rd_in_range ? mem[rd_idx] : '0;
            q_t1 <= q_t0;
        end
    end

    assign rd_q = q_t1;

endmodule

// File: tb/tb_param_stream_sink.sv
// Directed bench for param_stream_sink: a small model predicts ready/count/full and the
// read-data queue, and every cycle is checked with immediate assertions.
module tb_param_stream_sink;

    localparam int IN_SIZE  = 32;
    localparam int IN_WIDTH = 16;
    localparam int IN_DEPTH = 8;
    localparam int AW       = $clog2(IN_DEPTH) + 1;
    localparam int W        = IN_SIZE * IN_WIDTH;

    logic                clk;
    logic                rst;
    logic [IN_WIDTH-1:0] data_in [IN_SIZE];
    logic                data_in_valid;
    logic                data_in_ready;
    logic                rearm;
    logic                full;
    logic [AW-1:0]       count;
    logic [AW-1:0]       rd_addr;
    logic                rd_ce;
    logic [W-1:0]        rd_q;

    param_stream_sink #(
        .IN_SIZE(IN_SIZE), .IN_WIDTH(IN_WIDTH), .IN_DEPTH(IN_DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .rearm(rearm), .full(full), .count(count),
        .rd_addr(rd_addr), .rd_ce(rd_ce), .rd_q(rd_q)
    );

    int           vectors;
    int           miscompares;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_mem [IN_DEPTH];
    logic         exp_full;
    int           exp_count;
    int           exp_wptr;
    logic [W-1:0] exp_rdq;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] seq_word(input int base);
        logic [W-1:0] w;
        for (int j = 0; j < IN_SIZE; j++) w[IN_WIDTH*j +: IN_WIDTH] = 16'(base + j);
        return w;
    endfunction

    function automatic logic [W-1:0] all_word(input logic [15:0] v);
        logic [W-1:0] w;
        for (int j = 0; j < IN_SIZE; j++) w[IN_WIDTH*j +: IN_WIDTH] = v;
        return w;
    endfunction

    task automatic set_data(input logic [W-1:0] w);
        for (int j = 0; j < IN_SIZE; j++) data_in[j] = w[IN_WIDTH*j +: IN_WIDTH];
    endtask

    function automatic logic [W-1:0] cur_word();
        logic [W-1:0] w;
        for (int j = 0; j < IN_SIZE; j++) w[IN_WIDTH*j +: IN_WIDTH] = data_in[j];
        return w;
    endfunction

    task automatic model_reset();
        exp_full  = 1'b0;
        exp_count = 0;
        exp_wptr  = 0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_rdq = '0;
    endtask

    // One clock: inputs were set at the preceding falling edge by the caller.
    task automatic tick();
        logic         exp_ready;
        logic         acc;
        logic [W-1:0] rexp;
        #1;
        exp_ready = !exp_full && !rearm;
        check("ready", W'(data_in_ready), W'(exp_ready));
        acc  = data_in_valid && exp_ready;
        rexp = (int'(rd_addr) < IN_DEPTH) ? model_mem[rd_addr[AW-2:0]] : '0;
        @(posedge clk);
        if (rd_ce) begin
            exp_q.push_back(rexp);
            exp_rdq = exp_q.pop_front();
        end
        if (!exp_full) begin
            if (rearm) begin
                exp_count = 0;
                exp_wptr  = 0;
            end else if (acc) begin
                model_mem[exp_wptr] = cur_word();
                exp_count++;
                if (exp_wptr == IN_DEPTH - 1) begin
                    exp_wptr = 0;
                    exp_full = 1'b1;
                end else begin
                    exp_wptr++;
                end
            end
        end else if (rearm) begin
            exp_full  = 1'b0;
            exp_count = 0;
            exp_wptr  = 0;
        end
        @(negedge clk);
        check("count", W'(count), W'(exp_count));
        check("full", W'(full), W'(exp_full));
        check("rd_q", rd_q, exp_rdq);
    endtask

    task automatic send(input logic [W-1:0] w);
        set_data(w);
        data_in_valid = 1'b1;
        tick();
    endtask

    task automatic read(input int a);
        rd_addr = AW'(a);
        rd_ce   = 1'b1;
        tick();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        data_in_valid = 1'b0;
        rearm         = 1'b0;
        rd_addr       = '0;
        rd_ce         = 1'b0;
        set_data('0);
        model_reset();

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        #1;
        check("rst_full", W'(full), '0);
        check("rst_count", W'(count), '0);
        check("rst_rd_q", rd_q, '0);
        check("rst_ready", W'(data_in_ready), W'(1));
        @(negedge clk);
        rst = 1'b1;

        // Fill a block with valid held high, then verify ready drops.
        for (int b = 0; b < IN_DEPTH; b++) send(seq_word(b * 32));
        send(all_word(16'hAAAA));

        // Readback sweep including the out-of-range address.
        data_in_valid = 1'b1;
        for (int a = 0; a <= IN_DEPTH; a++) read(a);
        read(IN_DEPTH);
        read(IN_DEPTH);
        rd_ce = 1'b0;

        // Backpressure while full, then confirm mem[0] untouched.
        repeat (5) tick();
        read(0);
        read(0);
        rd_ce = 1'b0;

        // Rearm: the pending beat is accepted into address 0 afterwards.
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        tick();
        data_in_valid = 1'b0;
        read(0);
        read(0);
        rd_ce = 1'b0;

        // Rearm during fill aborts the partial block.
        send(all_word(16'h0101));
        send(all_word(16'h0202));
        data_in_valid = 1'b0;
        tick();
        set_data(all_word(16'h0BEE));
        data_in_valid = 1'b1;
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        tick();
        data_in_valid = 1'b0;
        read(0);
        read(0);
        rd_ce = 1'b0;

        // Random valid gaps until five beats are held.
        for (int k = 0; k < 200 && exp_count < 5; k++) begin
            set_data(seq_word(int'($urandom_range(0, 16'hFFFF))));
            data_in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        check("gap_count_reached", W'(exp_count), W'(5));

        // Asynchronous reset in the middle of a clock phase.
        data_in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_full", W'(full), '0);
        check("async_count", W'(count), '0);
        check("async_rd_q", rd_q, '0);
        @(negedge clk);
        rst = 1'b1;

        // Recovery fill, then a block with 0x5555 at address 2.
        for (int b = 0; b < IN_DEPTH; b++) send(seq_word(b * 32 + 7));
        rearm = 1'b1;
        data_in_valid = 1'b0;
        tick();
        rearm = 1'b0;
        for (int b = 0; b < IN_DEPTH; b++) send((b == 2) ? all_word(16'h5555) : seq_word(b * 3));
        rearm = 1'b1;
        data_in_valid = 1'b0;
        tick();
        rearm = 1'b0;
        send(all_word(16'h1111));
        send(all_word(16'h2222));

        // Collision: write 0x1234 to address 2 while reading address 2.
        set_data(all_word(16'h1234));
        data_in_valid = 1'b1;
        rd_addr = AW'(2);
        rd_ce = 1'b1;
        tick();
        data_in_valid = 1'b0;
        read(2);
        check("collision_old", rd_q, all_word(16'h5555));
        read(2);
        read(2);
        check("collision_new", rd_q, all_word(16'h1234));
        rd_ce = 1'b0;
        rd_addr = AW'(5);
        repeat (3) tick();
        check("hold_rd_q", rd_q, all_word(16'h1234));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
